// File: rtl/conv_window_gen_if.sv
// Pixel-stream in / 3x3 window out bundle for the conv2d window generator.
interface conv_window_gen_if #(
  parameter int DATA_W = 32
);
  logic              enable;
  logic [DATA_W-1:0] pixel_in;
  logic [DATA_W-1:0] w1, w2, w3, w4, w5, w6, w7, w8, w9;
  logic              valid_out;
  logic              frame_done;

  // Pixel source / window consumer side.
  modport master (
    output enable, pixel_in,
    input  w1, w2, w3, w4, w5, w6, w7, w8, w9, valid_out, frame_done
  );

  // Window generator side.
  modport slave (
    input  enable, pixel_in,
    output w1, w2, w3, w4, w5, w6, w7, w8, w9, valid_out, frame_done
  );
endinterface

// File: rtl/conv_window_gen.sv
// Raster FP32 pixel stream -> 3x3 interior windows for the conv2d ALU.
// Two line buffers indexed by column give the pixels one and two rows up;
// the window is a 3-column shift register fed from those and pixel_in.
module conv_window_gen #(
  parameter int IMG_WIDTH  = 28,
  parameter int IMG_HEIGHT = 28,
  parameter int DATA_W     = 32
) (
  input  logic              clk,
  input  logic              reset,
  conv_window_gen_if.slave  bus
);
  localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

  logic [CW-1:0]     col;
  logic [RW-1:0]     row;
  logic [DATA_W-1:0] lb1 [IMG_WIDTH];
  logic [DATA_W-1:0] lb2 [IMG_WIDTH];
  logic [DATA_W-1:0] win [9];
  logic              valid_q, done_q;

  logic accept, last_col, last_row, interior;
  logic [DATA_W-1:0] up1, up2;

  assign accept   = bus.enable;
  assign last_col = (col == CW'(IMG_WIDTH - 1));
  assign last_row = (row == RW'(IMG_HEIGHT - 1));
  assign interior = (row >= RW'(2)) && (col >= CW'(2));
  // Each column slot is rewritten once per row, so reading before the
  // write yields exactly IMG_WIDTH accepted pixels of delay.
  assign up1 = lb1[col];
  assign up2 = lb2[col];

  // Line buffers: data only, no reset; cascaded so lb2 lags lb1 by a row.
  always_ff @(posedge clk) begin
    if (accept && !reset) begin
      lb1[col] <= bus.pixel_in;
      lb2[col] <= up1;
    end
  end

  // Raster counters, window shift and registered strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      col     <= '0;
      row     <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      for (int i = 0; i < 9; i++) win[i] <= '0;
    end else begin
      valid_q <= accept && interior;
      done_q  <= accept && last_row && last_col;
      if (accept) begin
        if (last_col) begin
          col <= '0;
          row <= last_row ? '0 : row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
        win[0] <= win[1];
        win[1] <= win[2];
        win[2] <= up2;
        win[3] <= win[4];
        win[4] <= win[5];
        win[5] <= up1;
        win[6] <= win[7];
        win[7] <= win[8];
        win[8] <= bus.pixel_in;
      end
    end
  end

  assign bus.w1 = win[0];
  assign bus.w2 = win[1];
  assign bus.w3 = win[2];
  assign bus.w4 = win[3];
  assign bus.w5 = win[4];
  assign bus.w6 = win[5];
  assign bus.w7 = win[6];
  assign bus.w8 = win[7];
  assign bus.w9 = win[8];
  assign bus.valid_out  = valid_q;
  assign bus.frame_done = done_q;
endmodule
